rename_map_table: RTL and testbench

- Parametrised successor of the integer rename map table: N-wide speculative RAT plus a committed (retirement) RAT.
- Integrated circular checkpoint store with in-order allocate/release. Recovery from a checkpoint on branch mispredict, or from the committed RAT on exception flush.
- Sits in the frontend rename stage. The free list is external: physical destinations arrive as inputs.

---
 rtl/rename_pkg.sv | 17 +
 rtl/rat_ckpt_store.sv | 28 ++
 rtl/rename_map_table.sv | 132 +++++++++++++
 tb/tb_rename_map_table.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared sizing defaults and index types for the rename map table and its checkpoint store.
package rename_pkg;
    localparam int DEF_WIDTH        = 4;
    localparam int DEF_COMMIT_WIDTH = 4;
    localparam int DEF_ARCH_REGS    = 32;
    localparam int DEF_PHYS_REGS    = 64;
    localparam int DEF_CKPT_NUM     = 8;

    localparam int AW = $clog2(DEF_ARCH_REGS);
    localparam int PW = $clog2(DEF_PHYS_REGS);
    localparam int CW = $clog2(DEF_CKPT_NUM);

    typedef logic [AW-1:0] arch_idx_t;
    typedef logic [PW-1:0] phys_idx_t;
    typedef logic [CW-1:0] ckpt_id_t;
    typedef phys_idx_t [DEF_ARCH_REGS-1:0] rat_t;
endpackage

// File: rtl/rat_ckpt_store.sv
// Checkpoint RAT storage: one snapshot write per rename slot, one async read for recovery.
module rat_ckpt_store
    import rename_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int PHYS_REGS = DEF_PHYS_REGS,
    parameter int CKPT_NUM  = DEF_CKPT_NUM,
    localparam int SPW      = $clog2(PHYS_REGS),
    localparam int SCW      = $clog2(CKPT_NUM)
) (
    input  logic                                        clock,
    input  logic [WIDTH-1:0]                            wr_en,
    input  logic [WIDTH-1:0][SCW-1:0]                   wr_id,
    input  logic [WIDTH-1:0][ARCH_REGS-1:0][SPW-1:0]    wr_rat,
    input  logic [SCW-1:0]                              rd_id,
    output logic [ARCH_REGS-1:0][SPW-1:0]               rd_rat
);
    logic [ARCH_REGS-1:0][SPW-1:0] mem [CKPT_NUM];

    // Ids within one group are distinct, so slot order never matters here.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++)
            if (wr_en[i]) mem[wr_id[i]] <= wr_rat[i];
    end

    assign rd_rat = mem[rd_id];
endmodule

// File: rtl/rename_map_table.sv
// N-wide speculative RAT with committed RAT, circular checkpoints, mispredict and flush recovery.
module rename_map_table
    import rename_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int COMMIT_WIDTH = DEF_COMMIT_WIDTH,
    parameter int ARCH_REGS    = DEF_ARCH_REGS,
    parameter int PHYS_REGS    = DEF_PHYS_REGS,
    parameter int CKPT_NUM     = DEF_CKPT_NUM,
    localparam int MAW         = $clog2(ARCH_REGS),
    localparam int MPW         = $clog2(PHYS_REGS),
    localparam int MCW         = $clog2(CKPT_NUM),
    localparam int PTR_W       = MCW + 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   rd_valid,
    input  logic [WIDTH-1:0][MAW-1:0]          rs1,
    input  logic [WIDTH-1:0][MAW-1:0]          rs2,
    input  logic [WIDTH-1:0][MAW-1:0]          rd,
    input  logic [WIDTH-1:0][MPW-1:0]          new_prd,
    input  logic [WIDTH-1:0]                   ckpt_req,
    output logic [WIDTH-1:0][MPW-1:0]          prs1,
    output logic [WIDTH-1:0][MPW-1:0]          prs2,
    output logic [WIDTH-1:0][MPW-1:0]          prev_prd,
    output logic [WIDTH-1:0][MCW-1:0]          ckpt_id,
    input  logic                               ckpt_release,
    input  logic                               recover,
    input  logic [MCW-1:0]                     recover_id,
    input  logic                               flush,
    input  logic [COMMIT_WIDTH-1:0]            commit_valid,
    input  logic [COMMIT_WIDTH-1:0][MAW-1:0]   commit_rd,
    input  logic [COMMIT_WIDTH-1:0][MPW-1:0]   commit_prd,
    output logic [PTR_W-1:0]                   ckpt_count
);
    typedef logic [ARCH_REGS-1:0][MPW-1:0] rat_w_t;

    rat_w_t                   spec_rat, comm_rat, comm_next, snap_rat;
    logic [WIDTH:0][ARCH_REGS-1:0][MPW-1:0] stage;
    logic [PTR_W-1:0]         head, tail, n_req, run, rec_tail;
    logic [MCW-1:0]           rec_off;
    logic [WIDTH-1:0]         snap_en;
    logic                     fire;

    assign ckpt_count = tail - head;

    always_comb begin
        n_req = '0;
        for (int i = 0; i < WIDTH; i++)
            n_req = n_req + PTR_W'(ckpt_req[i] & in_valid);
    end

    assign in_ready = !flush && !recover && ((PTR_W'(CKPT_NUM) - ckpt_count) >= n_req);
    assign fire     = in_valid && in_ready;

    // stage[i] is the map as slot i sees it; stage[i+1] is also slot i's snapshot.
    always_comb begin
        stage[0] = spec_rat;
        run      = tail;
        for (int i = 0; i < WIDTH; i++) begin
            stage[i+1]  = stage[i];
            prs1[i]     = '0;
            prs2[i]     = '0;
            prev_prd[i] = '0;
            ckpt_id[i]  = '0;
            snap_en[i]  = 1'b0;
            if (fire) begin
                if (rs1[i] != '0) prs1[i] = stage[i][rs1[i]];
                if (rs2[i] != '0) prs2[i] = stage[i][rs2[i]];
                if (rd_valid[i] && rd[i] != '0) begin
                    prev_prd[i]       = stage[i][rd[i]];
                    stage[i+1][rd[i]] = new_prd[i];
                end
                if (ckpt_req[i]) begin
                    ckpt_id[i] = run[MCW-1:0];
                    snap_en[i] = 1'b1;
                    run        = run + PTR_W'(1);
                end
            end
        end
    end

    always_comb begin
        comm_next = comm_rat;
        for (int c = 0; c < COMMIT_WIDTH; c++)
            if (commit_valid[c] && commit_rd[c] != '0) comm_next[commit_rd[c]] = commit_prd[c];
    end

    // Rebuild the wrap bit for recover_id from its distance past head.
    assign rec_off  = recover_id - head[MCW-1:0];
    assign rec_tail = head + PTR_W'(rec_off) + PTR_W'(1);

    rat_ckpt_store #(
        .WIDTH(WIDTH), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .CKPT_NUM(CKPT_NUM)
    ) u_store (
        .clock  (clock),
        .wr_en  (snap_en & {WIDTH{!reset}}),
        .wr_id  (ckpt_id),
        .wr_rat (stage[WIDTH:1]),
        .rd_id  (recover_id),
        .rd_rat (snap_rat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                spec_rat[r] <= MPW'(r);
                comm_rat[r] <= MPW'(r);
            end
            head <= '0;
            tail <= '0;
        end else begin
            comm_rat <= comm_next;
            if (ckpt_release && ckpt_count != '0) head <= head + PTR_W'(1);
            if (flush) begin
                spec_rat <= comm_next;
                head     <= tail;
            end else if (recover) begin
                spec_rat <= snap_rat;
                tail     <= rec_tail;
            end else if (fire) begin
                spec_rat <= stage[WIDTH];
                tail     <= tail + n_req;
            end
        end
    end

    always @(posedge clock)
        if (!reset && ckpt_release) assert (ckpt_count != '0);
endmodule

// File: tb/tb_rename_map_table.sv
// Directed vector table plus hand sequences for checkpoint fill and mid-stream reset.
module tb_rename_map_table;
    import rename_pkg::*;
    localparam int W  = DEF_WIDTH;
    localparam int CM = DEF_COMMIT_WIDTH;

    logic clock, reset, in_valid, in_ready, ckpt_release, recover, flush;
    logic [W-1:0] rd_valid, ckpt_req;
    logic [W-1:0][AW-1:0] rs1, rs2, rd;
    logic [W-1:0][PW-1:0] new_prd, prs1, prs2, prev_prd;
    logic [W-1:0][CW-1:0] ckpt_id;
    logic [CW-1:0] recover_id;
    logic [CM-1:0] commit_valid;
    logic [CM-1:0][AW-1:0] commit_rd;
    logic [CM-1:0][PW-1:0] commit_prd;
    logic [CW:0] ckpt_count;

    int checks = 0;
    int failures = 0;

    rename_map_table dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rd_valid(rd_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .new_prd(new_prd),
        .ckpt_req(ckpt_req), .prs1(prs1), .prs2(prs2), .prev_prd(prev_prd),
        .ckpt_id(ckpt_id), .ckpt_release(ckpt_release), .recover(recover),
        .recover_id(recover_id), .flush(flush), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_prd(commit_prd), .ckpt_count(ckpt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic                 in_valid, rel, recover, flush;
        logic [CW-1:0]        recover_id;
        logic [W-1:0]         rd_valid, ckpt_req;
        logic [W-1:0][AW-1:0] rs1, rs2, rd;
        logic [W-1:0][PW-1:0] new_prd;
        logic [CM-1:0]        commit_valid;
        logic [CM-1:0][AW-1:0] commit_rd;
        logic [CM-1:0][PW-1:0] commit_prd;
        logic                 e_ready;
        logic [W-1:0][PW-1:0] e_prs1, e_prs2, e_prev;
        logic [W-1:0][CW-1:0] e_id;
        logic [CW:0]          e_count;
    } vec_t;

    vec_t vt[$];
    vec_t v;

    function automatic vec_t blank();
        vec_t b;
        b = '{default: '0};
        b.in_valid = 1'b1;
        b.e_ready  = 1'b1;
        return b;
    endfunction

    task automatic drive(input vec_t d);
        in_valid = d.in_valid; rd_valid = d.rd_valid; ckpt_req = d.ckpt_req;
        rs1 = d.rs1; rs2 = d.rs2; rd = d.rd; new_prd = d.new_prd;
        ckpt_release = d.rel; recover = d.recover; recover_id = d.recover_id; flush = d.flush;
        commit_valid = d.commit_valid; commit_rd = d.commit_rd; commit_prd = d.commit_prd;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        v = blank();
        v.in_valid = 1'b0;
        drive(v);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset.count", ckpt_count, 0);
        chk("reset.ready", in_ready, 1);
        next_cycle();

        // V0: identity lookup, x0 reads 0
        v = blank(); v.rs1[0] = 5; v.e_prs1[0] = 5; vt.push_back(v);
        // V1: intra-group bypass to slot1 source and prev_prd
        v = blank(); v.rd_valid = 4'b0011; v.rd[0] = 3; v.new_prd[0] = 40;
        v.rs1[1] = 3; v.rd[1] = 3; v.new_prd[1] = 41;
        v.e_prs1[1] = 40; v.e_prev[0] = 3; v.e_prev[1] = 40; vt.push_back(v);
        // V2: own rd does not bypass to own sources
        v = blank(); v.rs1[0] = 3; v.rs2[0] = 3; v.rd_valid[0] = 1; v.rd[0] = 3; v.new_prd[0] = 42;
        v.rs1[1] = 3; v.e_prs1[0] = 41; v.e_prs2[0] = 41; v.e_prev[0] = 41; v.e_prs1[1] = 42;
        vt.push_back(v);
        // V3: slot1 branch snapshot including its own rename 7->50
        v = blank(); v.ckpt_req[1] = 1; v.rd_valid[1] = 1; v.rd[1] = 7; v.new_prd[1] = 50;
        v.e_prev[1] = 7; v.e_id[1] = 0; vt.push_back(v);
        // V4: younger rename 7->51
        v = blank(); v.rd_valid[2] = 1; v.rd[2] = 7; v.new_prd[2] = 51; v.rs1[3] = 7;
        v.e_prev[2] = 50; v.e_prs1[3] = 51; v.e_count = 1; vt.push_back(v);
        // V5: recover to id 0, rename blocked
        v = blank(); v.recover = 1; v.recover_id = 0; v.rs1[0] = 7;
        v.e_ready = 0; v.e_count = 1; vt.push_back(v);
        // V6: restored map; two requests get consecutive ids
        v = blank(); v.rs1[0] = 7; v.rs2[0] = 3; v.ckpt_req = 4'b1010;
        v.e_prs1[0] = 50; v.e_prs2[0] = 42; v.e_id[1] = 1; v.e_id[3] = 2; v.e_count = 1;
        vt.push_back(v);
        // V7: commit 4->60 alongside speculative 4->61
        v = blank(); v.commit_valid[0] = 1; v.commit_rd[0] = 4; v.commit_prd[0] = 60;
        v.rd_valid[0] = 1; v.rd[0] = 4; v.new_prd[0] = 61; v.e_prev[0] = 4; v.e_count = 3;
        vt.push_back(v);
        // V8
        v = blank(); v.rs1[0] = 4; v.e_prs1[0] = 61; v.e_count = 3; vt.push_back(v);
        // V9: flush + recover + same-cycle commits (higher slot wins, rd 0 ignored)
        v = blank(); v.flush = 1; v.recover = 1; v.recover_id = 1; v.rs1[0] = 4;
        v.commit_valid = 4'b0111; v.commit_rd[0] = 9; v.commit_prd[0] = 69;
        v.commit_rd[1] = 0; v.commit_prd[1] = 5; v.commit_rd[2] = 9; v.commit_prd[2] = 70;
        v.e_ready = 0; v.e_count = 3; vt.push_back(v);
        // V10: map is the committed RAT, not snapshot 1 (which had 7->50)
        v = blank(); v.rs1[0] = 4; v.rs2[0] = 9; v.rs1[1] = 7; v.rs2[1] = 3;
        v.e_prs1[0] = 60; v.e_prs2[0] = 70; v.e_prs1[1] = 7; v.e_prs2[1] = 3; v.e_count = 0;
        vt.push_back(v);

        for (int k = 0; k < vt.size(); k++) begin
            drive(vt[k]);
            @(negedge clock);
            chk($sformatf("v%0d.ready", k), in_ready, vt[k].e_ready);
            chk($sformatf("v%0d.prs1", k), prs1, vt[k].e_prs1);
            chk($sformatf("v%0d.prs2", k), prs2, vt[k].e_prs2);
            chk($sformatf("v%0d.prev_prd", k), prev_prd, vt[k].e_prev);
            chk($sformatf("v%0d.ckpt_id", k), ckpt_id, vt[k].e_id);
            chk($sformatf("v%0d.count", k), ckpt_count, vt[k].e_count);
            next_cycle();
        end

        // Fill all 8 checkpoints starting at pointer 3, ids wrap 7 -> 0
        v = blank(); v.ckpt_req = 4'hF; drive(v);
        @(negedge clock);
        chk("fill0.ready", in_ready, 1);
        chk("fill0.id", ckpt_id, {3'd6, 3'd5, 3'd4, 3'd3});
        next_cycle();
        @(negedge clock);
        chk("fill1.id", ckpt_id, {3'd2, 3'd1, 3'd0, 3'd7});
        chk("fill1.count", ckpt_count, 4);
        next_cycle();
        v.ckpt_req = 4'b0001; drive(v);
        @(negedge clock);
        chk("full.count", ckpt_count, 8);
        chk("full.ready_req", in_ready, 0);
        v.ckpt_req = 4'b0000; drive(v);
        @(negedge clock);
        chk("full.ready_noreq", in_ready, 1);
        next_cycle();
        v.ckpt_req = 4'b0001; v.rel = 1; drive(v);
        @(negedge clock);
        chk("release.same_cycle_ready", in_ready, 0);
        next_cycle();
        v.rel = 0; drive(v);
        @(negedge clock);
        chk("release.count", ckpt_count, 7);
        chk("release.ready", in_ready, 1);
        chk("release.id", ckpt_id, {3'd0, 3'd0, 3'd0, 3'd3});
        next_cycle();

        // Reset mid-stream
        v = blank(); v.rd_valid[0] = 1; v.rd[0] = 5; v.new_prd[0] = 33; drive(v);
        next_cycle();
        v = blank(); v.rs1[0] = 5; drive(v);
        @(negedge clock);
        chk("pre_reset.prs1", prs1[0], 33);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        v = blank(); v.rs1[0] = 5; v.rs2[0] = 3; v.rs1[1] = 4; drive(v);
        @(negedge clock);
        chk("post_reset.prs1", prs1, {6'd0, 6'd0, 6'd4, 6'd5});
        chk("post_reset.prs2", prs2, {6'd0, 6'd0, 6'd0, 6'd3});
        chk("post_reset.count", ckpt_count, 0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
